// File: rtl/twiddle_gen_if.sv
// rtl/twiddle_gen_if.sv - Control inputs and twiddle outputs of twiddle_gen
interface twiddle_gen_if #(
  parameter int DW = 16
);
  logic            start;
  logic            in_valid;
  logic            radix4;
  logic            inverse;
  logic [2*DW-1:0] W1;
  logic [2*DW-1:0] W2;
  logic [2*DW-1:0] W3;
  logic            out_valid;
  logic [3:0]      stage;
  logic            last;
  logic            busy;

  modport master (
    output start, in_valid, radix4, inverse,
    input  W1, W2, W3, out_valid, stage, last, busy
  );

  modport slave (
    input  start, in_valid, radix4, inverse,
    output W1, W2, W3, out_valid, stage, last, busy
  );
endinterface

// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - Quarter-wave table twiddle generator for radix-2/radix-4 FFT stages
module twiddle_gen #(
  parameter int LOG2N = 11,
  parameter int DW    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  twiddle_gen_if.slave tw
);
  localparam int N  = 1 << LOG2N;
  localparam int QN = N / 4;
  // Table address spans 0..N/4 inclusive.
  localparam int AW = LOG2N - 1;
  // Radix-4 needs an even number of address bits.
  localparam bit R4_OK = (LOG2N % 2) == 0;

  localparam logic [LOG2N-1:0] BEAT_LAST_R2  = LOG2N'(N / 2 - 1);
  localparam logic [LOG2N-1:0] BEAT_LAST_R4  = LOG2N'(QN - 1);
  localparam logic [3:0]       STAGE_LAST_R2 = 4'(LOG2N - 1);
  localparam logic [3:0]       STAGE_LAST_R4 = 4'(LOG2N / 2 - 1);
  localparam logic [AW-1:0]    QN_A          = AW'(QN);

  // C[k] = round((2^(DW-1)-1) * cos(2*pi*k/N)) for 0 <= k <= N/4, evaluated at
  // elaboration with a 2^-30 fixed-point Taylor series (angle stays <= pi/2).
  function automatic logic [DW-1:0] cos_entry(input int k);
    longint pi_fx;
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint amp;
    longint v;
    pi_fx = 64'sd3373259426;
    x     = (longint'(2) * pi_fx * longint'(k)) / longint'(N);
    x2    = (x * x) >>> 30;
    term  = longint'(1) <<< 30;
    acc   = term;
    for (int n = 1; n <= 12; n++) begin
      term = -(((term * x2) >>> 30) / longint'(2 * n * (2 * n - 1)));
      acc  = acc + term;
    end
    amp = (longint'(1) <<< (DW - 1)) - 1;
    v   = (amp * acc + (longint'(1) <<< 29)) >>> 30;
    return DW'(v);
  endfunction

  logic [DW-1:0] cos_rom [QN+1];

  for (genvar k = 0; k <= QN; k++) begin : g_rom
    localparam logic [DW-1:0] ENTRY = cos_entry(k);
    assign cos_rom[k] = ENTRY;
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       stage_q, stage_d;
  logic [LOG2N-1:0] beat_q, beat_d;
  logic             r4_q, r4_d;
  logic             inv_q, inv_d;

  logic [3:0]       cur_stage;
  logic [LOG2N-1:0] cur_beat;
  logic             cur_r4;
  logic             cur_inv;
  logic             accept;
  logic             stage_end;
  logic             frame_end;

  logic [3:0]       shamt;
  logic [LOG2N-1:0] p;
  logic [LOG2N-1:0] e [3];
  logic [AW-1:0]    ac_d [3];
  logic [AW-1:0]    as_d [3];

  logic [AW-1:0]    ac_q [3];
  logic [AW-1:0]    as_q [3];
  logic [1:0]       q1_q [3];
  logic             v1_q, last1_q, r4_1_q, inv1_q;
  logic [3:0]       stage1_q;

  logic [DW-1:0]    c_q [3];
  logic [DW-1:0]    s_q [3];
  logic [1:0]       q2_q [3];
  logic             v2_q, last2_q, r4_2_q, inv2_q;
  logic [3:0]       stage2_q;

  logic [2*DW-1:0]  w_d [3];
  logic [2*DW-1:0]  w_q [3];
  logic             out_valid_q, last_q;
  logic [3:0]       stage_out_q;

  // Frame state and beat/stage counters; start overrides the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      beat_q  <= '0;
      r4_q    <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      beat_q  <= beat_d;
      r4_q    <= r4_d;
      inv_q   <= inv_d;
    end
  end

  // Next frame state; a beat coincident with start is beat 0 of the new frame.
  always_comb begin
    cur_stage = stage_q;
    cur_beat  = beat_q;
    cur_r4    = r4_q;
    cur_inv   = inv_q;
    state_d   = state_q;
    stage_d   = stage_q;
    beat_d    = beat_q;
    r4_d      = r4_q;
    inv_d     = inv_q;
    if (tw.start) begin
      cur_stage = '0;
      cur_beat  = '0;
      cur_r4    = tw.radix4 & R4_OK;
      cur_inv   = tw.inverse;
      state_d   = S_RUN;
      stage_d   = '0;
      beat_d    = '0;
      r4_d      = cur_r4;
      inv_d     = cur_inv;
    end
    accept    = tw.in_valid && (tw.start || state_q == S_RUN);
    stage_end = cur_beat == (cur_r4 ? BEAT_LAST_R4 : BEAT_LAST_R2);
    frame_end = stage_end && (cur_stage == (cur_r4 ? STAGE_LAST_R4 : STAGE_LAST_R2));
    if (accept) begin
      if (frame_end) begin
        state_d = S_IDLE;
        stage_d = '0;
        beat_d  = '0;
      end else if (stage_end) begin
        stage_d = cur_stage + 4'd1;
        beat_d  = '0;
      end else begin
        beat_d = cur_beat + LOG2N'(1);
      end
    end
  end

  // Exponents: the modulo in the schedule is a mask once the beat is shifted
  // left by the stage stride (2^s or 4^s); table addresses for c and s follow.
  always_comb begin
    shamt = cur_r4 ? {cur_stage[2:0], 1'b0} : cur_stage;
    p     = (cur_beat << shamt) & (cur_r4 ? BEAT_LAST_R4 : BEAT_LAST_R2);
    e[0]  = p;
    e[1]  = p << 1;
    e[2]  = p + (p << 1);
    for (int i = 0; i < 3; i++) begin
      ac_d[i] = AW'(e[i][LOG2N-3:0]);
      as_d[i] = QN_A - ac_d[i];
    end
  end

  // Pipeline cycle 1: exponent quadrant and table addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        ac_q[i] <= '0;
        as_q[i] <= '0;
        q1_q[i] <= '0;
      end
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      r4_1_q   <= 1'b0;
      inv1_q   <= 1'b0;
      stage1_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        ac_q[i] <= ac_d[i];
        as_q[i] <= as_d[i];
        q1_q[i] <= e[i][LOG2N-1:LOG2N-2];
      end
      v1_q     <= accept;
      last1_q  <= accept && frame_end;
      r4_1_q   <= cur_r4;
      inv1_q   <= cur_inv;
      stage1_q <= cur_stage;
    end
  end

  // Pipeline cycle 2: six synchronous table reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        c_q[i]  <= '0;
        s_q[i]  <= '0;
        q2_q[i] <= '0;
      end
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      r4_2_q   <= 1'b0;
      inv2_q   <= 1'b0;
      stage2_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        c_q[i]  <= cos_rom[ac_q[i]];
        s_q[i]  <= cos_rom[as_q[i]];
        q2_q[i] <= q1_q[i];
      end
      v2_q     <= v1_q;
      last2_q  <= last1_q;
      r4_2_q   <= r4_1_q;
      inv2_q   <= inv1_q;
      stage2_q <= stage1_q;
    end
  end

  // Quadrant sign/swap, optional conjugation, W2/W3 zeroed for radix-2.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      re = '0;
      im = '0;
      case (q2_q[i])
        2'd0:    begin re = c_q[i];  im = -s_q[i]; end
        2'd1:    begin re = -s_q[i]; im = -c_q[i]; end
        2'd2:    begin re = -c_q[i]; im = s_q[i];  end
        default: begin re = s_q[i];  im = c_q[i];  end
      endcase
      if (inv2_q) begin
        im = -im;
      end
      w_d[i] = (i == 0 || r4_2_q) ? {re, im} : '0;
    end
  end

  // Pipeline cycle 3: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        w_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      stage_out_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        w_q[i] <= w_d[i];
      end
      out_valid_q <= v2_q;
      last_q      <= last2_q;
      stage_out_q <= stage2_q;
    end
  end

  assign tw.W1        = w_q[0];
  assign tw.W2        = w_q[1];
  assign tw.W3        = w_q[2];
  assign tw.out_valid = out_valid_q;
  assign tw.last      = last_q;
  assign tw.stage     = stage_out_q;
  assign tw.busy      = state_q == S_RUN;

endmodule

// File: tb/tb_twiddle_gen.sv
// tb/tb_twiddle_gen.sv - Scoreboard bench for twiddle_gen at LOG2N=4 and LOG2N=5
module tb_twiddle_gen;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  twiddle_gen_if #(.DW(DW)) if0 ();
  twiddle_gen_if #(.DW(DW)) if1 ();

  twiddle_gen #(.LOG2N(4), .DW(DW)) u_dut0 (.clk(clk), .rst_n(rst_n), .tw(if0));
  twiddle_gen #(.LOG2N(5), .DW(DW)) u_dut1 (.clk(clk), .rst_n(rst_n), .tw(if1));

  typedef struct {
    logic [2*DW-1:0] w1;
    logic [2*DW-1:0] w2;
    logic [2*DW-1:0] w3;
    logic [3:0]      stage;
    logic            last;
    int              issue;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int lg[2] = '{4, 5};
  int m_act[2];
  int m_r4[2];
  int m_inv[2];
  int m_k[2];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, want, cyc);
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  // Ideal factor W^e = exp(-j*2*pi*e/n), rounded to the output format.
  function automatic logic [2*DW-1:0] tw_ref(input int n, input int e, input int inv);
    real a;
    real ang;
    int  re;
    int  im;
    a   = real'((1 << (DW - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * real'(e) / real'(n);
    re  = rnd(a * $cos(ang));
    im  = -rnd(a * $sin(ang));
    if (inv != 0) im = -im;
    return {re[DW-1:0], im[DW-1:0]};
  endfunction

  task automatic model_beat(input int d);
    int   n, bps, ns, total, s, b, p;
    exp_t x;
    n     = 1 << lg[d];
    bps   = (m_r4[d] != 0) ? n / 4 : n / 2;
    ns    = (m_r4[d] != 0) ? lg[d] / 2 : lg[d];
    total = ns * bps;
    s     = m_k[d] / bps;
    b     = m_k[d] % bps;
    if (m_r4[d] != 0) p = (b % (n >> (2 * s + 2))) * (1 << (2 * s));
    else              p = (b % (n >> (s + 1))) * (1 << s);
    x.w1    = tw_ref(n, p, m_inv[d]);
    x.w2    = (m_r4[d] != 0) ? tw_ref(n, (2 * p) % n, m_inv[d]) : '0;
    x.w3    = (m_r4[d] != 0) ? tw_ref(n, (3 * p) % n, m_inv[d]) : '0;
    x.stage = 4'(s);
    x.last  = (m_k[d] == total - 1);
    x.issue = cyc;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
    m_k[d]++;
    if (x.last) m_act[d] = 0;
  endtask

  // Present one cycle of stimulus to DUT d (the other DUT sees idle inputs).
  task automatic drive(input int d, input bit st, input bit iv, input bit r4, input bit inv);
    if0.start    = (d == 0) && st;
    if0.in_valid = (d == 0) && iv;
    if0.radix4   = r4;
    if0.inverse  = inv;
    if1.start    = (d == 1) && st;
    if1.in_valid = (d == 1) && iv;
    if1.radix4   = r4;
    if1.inverse  = inv;
    if (st) begin
      m_act[d] = 1;
      m_r4[d]  = (r4 && (lg[d] % 2 == 0)) ? 1 : 0;
      m_inv[d] = inv ? 1 : 0;
      m_k[d]   = 0;
    end
    if (iv && m_act[d] != 0) model_beat(d);
    @(posedge clk);
    #1;
    chk($sformatf("d%0d busy", d), (d == 0) ? if0.busy : if1.busy, m_act[d]);
  endtask

  task automatic idle(input int d, input int cycles);
    for (int i = 0; i < cycles; i++) drive(d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mon(input string tag, input logic ov, input logic [2*DW-1:0] w1,
                     input logic [2*DW-1:0] w2, input logic [2*DW-1:0] w3,
                     input logic [3:0] st, input logic lst, ref exp_t q[$]);
    exp_t x;
    if (ov) begin
      chk({tag, " out_valid has pending beat"}, longint'(q.size() > 0), 1);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk({tag, " latency"}, cyc - x.issue, 3);
        chk({tag, " W1"}, w1, x.w1);
        chk({tag, " W2"}, w2, x.w2);
        chk({tag, " W3"}, w3, x.w3);
        chk({tag, " stage"}, st, x.stage);
        chk({tag, " last"}, lst, x.last);
      end
    end else if (q.size() > 0 && cyc - q[0].issue > 3) begin
      chk({tag, " out_valid when due"}, ov, 1);
      x = q.pop_front();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon("d0", if0.out_valid, if0.W1, if0.W2, if0.W3, if0.stage, if0.last, q0);
      mon("d1", if1.out_valid, if1.W1, if1.W2, if1.W3, if1.stage, if1.last, q1);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " d0 W1"}, if0.W1, 0);
    chk({tag, " d0 W2"}, if0.W2, 0);
    chk({tag, " d0 W3"}, if0.W3, 0);
    chk({tag, " d0 out_valid"}, if0.out_valid, 0);
    chk({tag, " d0 last"}, if0.last, 0);
    chk({tag, " d0 busy"}, if0.busy, 0);
    chk({tag, " d0 stage"}, if0.stage, 0);
    chk({tag, " d1 out_valid"}, if1.out_valid, 0);
    chk({tag, " d1 busy"}, if1.busy, 0);
    chk({tag, " d1 W1"}, if1.W1, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_r4[d] = 0; m_inv[d] = 0; m_k[d] = 0;
    end
    if0.start = 0; if0.in_valid = 0; if0.radix4 = 0; if0.inverse = 0;
    if1.start = 0; if1.in_valid = 0; if1.radix4 = 0; if1.inverse = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    idle(0, 2);

    // in_valid while idle must be ignored
    for (int i = 0; i < 4; i++) drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle in_valid out_valid", if0.out_valid, 0);
    end

    // radix-2 forward, 32 back-to-back beats
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 5);

    // radix-4 forward, first beat together with start
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 5);

    // radix-4 inverse, 1-on/2-off gaps
    drive(0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(0, 2);
    end
    idle(0, 5);

    // restart mid-frame
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 5);

    // odd LOG2N: radix4 request falls back to radix-2 (80 beats)
    drive(1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    idle(1, 5);

    // random traffic with occasional restarts
    for (int i = 0; i < 400; i++) begin
      drive(0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(0, 5);

    // reset in the middle of a frame
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    if0.in_valid = 0; if0.start = 0;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    m_act[0] = 0;
    m_act[1] = 0;
    @(negedge clk);
    chk_zero("midframe reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("post reset out_valid", if0.out_valid, 0);
    end

    idle(0, 6);
    chk("d0 scoreboard drained", q0.size(), 0);
    chk("d1 scoreboard drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
